// File: rtl/rv32i_encoder.sv
// rv32i_encoder: packs decoded RV32I fields into 32-bit instruction words with byte addresses.
// Latency 1 cycle from accept to out_valid; 1 word/cycle when out_ready is held high.
// Backpressure: word held stable while out_valid && !out_ready; in_ready = !clear && (!out_valid || out_ready).
// Optional immediate range checking is enabled by defining RV32I_ENCODER_RANGE_CHECK_EN.

package rv32i_encoder_pkg;
   typedef enum logic [2:0] {
      RTYPE = 3'd0,
      ITYPE = 3'd1,
      STYPE = 3'd2,
      BTYPE = 3'd3,
      UTYPE = 3'd4,
      JTYPE = 3'd5
   } optype_e;
endpackage

module rv32i_encoder
   import rv32i_encoder_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  optype_e           in_optype,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [7:0]        err_count
);

   logic [ADDR_W-1:0] next_addr;
   logic [31:0]       word;
   logic              legal;
   logic              accept;

   // A held word only blocks new input while downstream is stalling it; clear blocks everything.
   assign in_ready = !clear && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Scatter fields into the instruction word according to the format.
   always_comb begin
      word = '0;
      case (in_optype)
         RTYPE: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         ITYPE: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         STYPE: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         BTYPE: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
         UTYPE: word = {in_imm[31:12], in_rd, in_opcode};
         JTYPE: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         default: word = '0;
      endcase
   end

`ifdef RV32I_ENCODER_RANGE_CHECK_EN
   // An immediate is legal only if the bits the format drops are pure sign extension
   // (and, for branch/jump offsets, the implied-zero LSB really is zero).
   always_comb begin
      legal = 1'b1;
      case (in_optype)
         ITYPE, STYPE: legal = (&in_imm[31:11]) || !(|in_imm[31:11]);
         BTYPE:        legal = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
         JTYPE:        legal = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
         UTYPE:        legal = !(|in_imm[11:0]);
         default:      legal = 1'b1;
      endcase
   end

   // Error pulse follows each rejected accept; the counter sticks at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err       <= 1'b0;
         err_count <= 8'd0;
      end else if (clear) begin
         err       <= 1'b0;
         err_count <= 8'd0;
      end else begin
         err <= accept && !legal;
         if (accept && !legal && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end
`else
   assign legal     = 1'b1;
   assign err       = 1'b0;
   assign err_count = 8'd0;
`endif

   // Output register and address counter: drain on out_ready, reload on a legal accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= '0;
         next_addr <= BASE_ADDR;
      end else if (clear) begin
         out_valid <= 1'b0;
         next_addr <= BASE_ADDR;
      end else begin
         if (out_ready)
            out_valid <= 1'b0;
         if (accept && legal) begin
            out_valid <= 1'b1;
            out_instr <= word;
            out_addr  <= next_addr;
            next_addr <= next_addr + ADDR_W'(4);
         end
      end
   end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed bench for rv32i_encoder: packing table plus handshake, clear, reset and wrap sequences.
module tb_rv32i_encoder;
   import rv32i_encoder_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   optype_e     in_optype;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [15:0] out_addr;
   logic        err;
   logic [7:0]  err_count;

   int checks   = 0;
   int failures = 0;

   rv32i_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_optype(in_optype), .in_opcode(in_opcode),
      .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      optype_e     t;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input optype_e t, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm);
      in_optype = t;
      in_opcode = op;
      in_funct3 = f3;
      in_funct7 = f7;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_rd     = rd;
      in_imm    = imm;
      in_valid  = 1'b1;
   endtask

   task automatic do_clear();
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
   endtask

   logic [15:0] exp_addr;

   initial begin
      vecs[0] = '{"sw",     STYPE, 7'h23, 3'd2, 7'h00, 5'd1,  5'd2,  5'd0, 32'd8,        32'h0020A423};
      vecs[1] = '{"beq",    BTYPE, 7'h63, 3'd0, 7'h00, 5'd1,  5'd2,  5'd0, 32'hFFFFFFFC, 32'hFE208EE3};
      vecs[2] = '{"jal",    JTYPE, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1, 32'h00000800, 32'h001000EF};
      vecs[3] = '{"sub",    RTYPE, 7'h33, 3'd0, 7'h20, 5'd1,  5'd2,  5'd3, 32'hFFFFFFFF, 32'h402081B3};
      vecs[4] = '{"lui",    UTYPE, 7'h37, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd5, 32'h12345000, 32'h123452B7};
      vecs[5] = '{"addi_m1",ITYPE, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd2, 32'hFFFFFFFF, 32'hFFF08113};
      vecs[6] = '{"jal_m8", JTYPE, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 32'hFFFFFFF8, 32'hFF9FF06F};
      vecs[7] = '{"srai",   ITYPE, 7'h13, 3'd5, 7'h00, 5'd1,  5'd0,  5'd1, 32'h00000403, 32'h4030D093};
      vecs[8] = '{"add",    RTYPE, 7'h33, 3'd0, 7'h00, 5'd1,  5'd2,  5'd3, 32'h0,        32'h002081B3};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(ITYPE, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
      in_valid = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr",  32'(out_addr), 32'd0);
      chk("rst_err",       32'(err), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // ADDI x1,x0,5 appears one cycle after accept at address 0.
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("addi_valid", 32'(out_valid), 32'd1);
      chk("addi_instr", out_instr, 32'h00500093);
      chk("addi_addr",  32'(out_addr), 32'h0);
      @(negedge clk);
      chk("addi_drained", 32'(out_valid), 32'd0);

      // Table streamed back-to-back from address 0; every cycle must carry a word.
      do_clear();
      exp_addr = 16'h0;
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].t, vecs[i].op, vecs[i].f3, vecs[i].f7,
               vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm);
         @(negedge clk);
         chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
         chk({vecs[i].name, "_instr"}, out_instr, vecs[i].exp);
         chk({vecs[i].name, "_addr"},  32'(out_addr), 32'(exp_addr));
         exp_addr = exp_addr + 16'd4;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("table_drained", 32'(out_valid), 32'd0);

      // Out-of-range I immediate.
      do_clear();
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'h800);
      @(negedge clk);
`ifdef RV32I_ENCODER_RANGE_CHECK_EN
      chk("rng_i_valid", 32'(out_valid), 32'd0);
      chk("rng_i_err",   32'(err), 32'd1);
      chk("rng_i_cnt",   32'(err_count), 32'd1);
      drive(BTYPE, 7'h63, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, 32'h5);
      @(negedge clk);
      chk("rng_b_err", 32'(err), 32'd1);
      chk("rng_b_cnt", 32'(err_count), 32'd2);
      drive(UTYPE, 7'h37, 3'd0, 7'h0, 5'd0, 5'd0, 5'd5, 32'h12345001);
      @(negedge clk);
      chk("rng_u_cnt", 32'(err_count), 32'd3);
      drive(JTYPE, 7'h6F, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'h00100000);
      @(negedge clk);
      chk("rng_j_cnt",   32'(err_count), 32'd4);
      chk("rng_j_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("rng_err_pulse_end", 32'(err), 32'd0);
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rng_next_valid", 32'(out_valid), 32'd1);
      chk("rng_next_addr",  32'(out_addr), 32'h0);
      // Saturation of the error counter.
      do_clear();
      drive(STYPE, 7'h23, 3'd2, 7'h0, 5'd1, 5'd2, 5'd0, 32'h00001000);
      repeat (260) @(negedge clk);
      in_valid = 1'b0;
      chk("sat_cnt",   32'(err_count), 32'd255);
      chk("sat_valid", 32'(out_valid), 32'd0);
`else
      in_valid = 1'b0;
      chk("trunc_valid", 32'(out_valid), 32'd1);
      chk("trunc_instr", out_instr, 32'h80000093);
      chk("trunc_addr",  32'(out_addr), 32'h0);
      chk("trunc_err",   32'(err), 32'd0);
      chk("trunc_cnt",   32'(err_count), 32'd0);
`endif

      // Backpressure: first word held for three stalled cycles, second accepted on release.
      do_clear();
      out_ready = 1'b0;
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      drive(STYPE, 7'h23, 3'd2, 7'h0, 5'd1, 5'd2, 5'd0, 32'd8);
      for (int c = 0; c < 3; c++) begin
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_instr", out_instr, 32'h00500093);
         chk("bp_hold_addr",  32'(out_addr), 32'h0);
         chk("bp_in_ready",   32'(in_ready), 32'd0);
         if (c < 2) @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_instr", out_instr, 32'h0020A423);
      chk("bp_second_addr",  32'(out_addr), 32'h4);

      // Clear while a word is held.
      @(negedge clk);
      out_ready = 1'b0;
`ifdef RV32I_ENCODER_RANGE_CHECK_EN
      drive(UTYPE, 7'h37, 3'd0, 7'h0, 5'd0, 5'd0, 5'd5, 32'h1);
      @(negedge clk);
      chk("clr_pre_cnt", 32'(err_count), 32'd1);
`endif
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("clr_held_valid", 32'(out_valid), 32'd1);
      chk("clr_held_addr",  32'(out_addr), 32'h8);
      clear = 1'b1;
      #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      clear = 1'b0;
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_cnt",   32'(err_count), 32'd0);
      out_ready = 1'b1;
      drive(JTYPE, 7'h6F, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'h800);
      @(negedge clk);
      in_valid = 1'b0;
      chk("clr_next_instr", out_instr, 32'h001000EF);
      chk("clr_next_addr",  32'(out_addr), 32'h0);

      // Asynchronous reset discards a held word immediately.
      @(negedge clk);
      out_ready = 1'b0;
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("arst_held", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1 chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_instr", out_instr, 32'd0);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("arst_next_addr", 32'(out_addr), 32'h0);

      // Address wraps modulo 2^16.
      do_clear();
      drive(ITYPE, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
      repeat (16384) @(negedge clk);
      chk("wrap_last_addr", 32'(out_addr), 32'hFFFC);
      @(negedge clk);
      in_valid = 1'b0;
      chk("wrap_addr", 32'(out_addr), 32'h0000);
      chk("wrap_valid", 32'(out_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
